dram_arb: RTL and testbench

DRAM_ARB -- requirements
Module: dram_arb

---
 rtl/dram_pkg.sv | 15 +
 rtl/dram_slotctr.sv | 19 +
 rtl/dram_arb.sv | 120 ++++++++++++
 tb/tb_dram_arb.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/dram_pkg.sv
// dram_pkg: slot length, slot-owner encoding and DRAM byte-select constants
package dram_pkg;
    localparam int SLOT_LEN = 4;
    typedef enum logic [1:0] {
        OWN_IDLE  = 2'd0,
        OWN_CPU   = 2'd1,
        OWN_VIDEO = 2'd2
    } owner_t;
    localparam logic [1:0] BSEL_LO = 2'b01;
    localparam logic [1:0] BSEL_HI = 2'b10;
    localparam logic [1:0] BSEL_W  = 2'b11;
    function automatic logic [1:0] cpu_bsel(input logic rnw, input logic wrbsel);
        return rnw ? BSEL_W : (wrbsel ? BSEL_LO : BSEL_HI);
    endfunction
endpackage

// File: rtl/dram_slotctr.sv
// dram_slotctr: free-running slot phase counter with pre_cend/cend strobes
module dram_slotctr
    import dram_pkg::*;
(
    input  logic fclk,
    input  logic rst_n,
    output logic pre_cend,
    output logic cend
);
    localparam logic [1:0] LAST = 2'(SLOT_LEN - 1);
    logic [1:0] cyc_q, cyc_d;
    always_comb cyc_d = cyc_q + 2'd1;
    always_ff @(posedge fclk) begin
        if (!rst_n) cyc_q <= 2'd0;
        else        cyc_q <= cyc_d;
    end
    assign pre_cend = cyc_q == LAST - 2'd1;
    assign cend     = cyc_q == LAST;
endmodule

// File: rtl/dram_arb.sv
// dram_arb: slot-based CPU/video DRAM arbiter with registered command and read capture
module dram_arb
    import dram_pkg::*;
(
    input  logic        fclk,
    input  logic        rst_n,
    input  logic        cpu_req,
    input  logic        cpu_rnw,
    input  logic [20:0] cpu_addr,
    input  logic [7:0]  cpu_wrdata,
    input  logic        cpu_wrbsel,
    output logic [15:0] cpu_rddata,
    output logic        cpu_strobe,
    input  logic        video_req,
    input  logic [20:0] video_addr,
    output logic [15:0] video_rddata,
    output logic        video_strobe,
    output logic        pre_cend,
    output logic        cend,
    output logic        dram_req,
    output logic        dram_rnw,
    output logic [20:0] dram_addr,
    output logic [15:0] dram_wrdata,
    output logic [1:0]  dram_bsel,
    input  logic [15:0] dram_rddata
);
    owner_t      own_q, own_d;
    logic        pend_q, pend_d, p_rnw_q, p_rnw_d, p_wrbsel_q, p_wrbsel_d;
    logic [20:0] p_addr_q, p_addr_d;
    logic [7:0]  p_wd_q, p_wd_d;
    logic        req_q, req_d, rnw_q, rnw_d;
    logic [20:0] addr_q, addr_d;
    logic [15:0] wd_q, wd_d;
    logic [1:0]  bsel_q, bsel_d;
    logic [15:0] crd_q, crd_d, vrd_q, vrd_d;
    logic        cstb_q, cstb_d, vstb_q, vstb_d;
    logic        c_rnw, c_wrbsel, g_cpu, g_vid, rd_end, load;
    logic [20:0] c_addr;
    logic [7:0]  c_wd;

    dram_slotctr u_slotctr (
        .fclk     (fclk),
        .rst_n    (rst_n),
        .pre_cend (pre_cend),
        .cend     (cend)
    );

    // own_q is the owner of the slot in progress, i.e. the one that ends at cend
    always_comb begin
        c_rnw      = pend_q ? p_rnw_q    : cpu_rnw;
        c_wrbsel   = pend_q ? p_wrbsel_q : cpu_wrbsel;
        c_addr     = pend_q ? p_addr_q   : cpu_addr;
        c_wd       = pend_q ? p_wd_q     : cpu_wrdata;
        g_cpu      = (cpu_req | pend_q) & (!video_req | own_q == OWN_VIDEO);
        g_vid      = video_req & !g_cpu;
        rd_end     = cend & req_q & rnw_q;
        load       = cend & !pend_q;
        pend_d     = cend ? (cpu_req | pend_q) & !g_cpu : pend_q;
        p_rnw_d    = load ? cpu_rnw    : p_rnw_q;
        p_wrbsel_d = load ? cpu_wrbsel : p_wrbsel_q;
        p_addr_d   = load ? cpu_addr   : p_addr_q;
        p_wd_d     = load ? cpu_wrdata : p_wd_q;
        own_d      = !cend ? own_q : g_cpu ? OWN_CPU : g_vid ? OWN_VIDEO : OWN_IDLE;
        req_d      = cend ? g_cpu | g_vid : req_q;
        rnw_d      = cend ? !g_cpu | c_rnw : rnw_q;
        addr_d     = (cend & g_cpu) ? c_addr : (cend & g_vid) ? video_addr : addr_q;
        wd_d       = (cend & g_cpu & !c_rnw) ? {c_wd, c_wd} : wd_q;
        bsel_d     = !cend ? bsel_q : g_cpu ? cpu_bsel(c_rnw, c_wrbsel) : g_vid ? BSEL_W : 2'b00;
        cstb_d     = rd_end & own_q == OWN_CPU;
        vstb_d     = rd_end & own_q == OWN_VIDEO;
        crd_d      = cstb_d ? dram_rddata : crd_q;
        vrd_d      = vstb_d ? dram_rddata : vrd_q;
    end

    always_ff @(posedge fclk) begin
        if (!rst_n) begin
            own_q      <= OWN_IDLE;
            pend_q     <= 1'b0;
            p_rnw_q    <= 1'b0;
            p_wrbsel_q <= 1'b0;
            p_addr_q   <= '0;
            p_wd_q     <= '0;
            req_q      <= 1'b0;
            rnw_q      <= 1'b1;
            addr_q     <= '0;
            wd_q       <= '0;
            bsel_q     <= 2'b00;
            crd_q      <= '0;
            vrd_q      <= '0;
            cstb_q     <= 1'b0;
            vstb_q     <= 1'b0;
        end else begin
            own_q      <= own_d;
            pend_q     <= pend_d;
            p_rnw_q    <= p_rnw_d;
            p_wrbsel_q <= p_wrbsel_d;
            p_addr_q   <= p_addr_d;
            p_wd_q     <= p_wd_d;
            req_q      <= req_d;
            rnw_q      <= rnw_d;
            addr_q     <= addr_d;
            wd_q       <= wd_d;
            bsel_q     <= bsel_d;
            crd_q      <= crd_d;
            vrd_q      <= vrd_d;
            cstb_q     <= cstb_d;
            vstb_q     <= vstb_d;
        end
    end

    assign dram_req     = req_q;
    assign dram_rnw     = rnw_q;
    assign dram_addr    = addr_q;
    assign dram_wrdata  = wd_q;
    assign dram_bsel    = bsel_q;
    assign cpu_rddata   = crd_q;
    assign cpu_strobe   = cstb_q;
    assign video_rddata = vrd_q;
    assign video_strobe = vstb_q;
endmodule

// File: tb/tb_dram_arb.sv
// tb_dram_arb: directed slot vectors with scoreboard queues checked by a negedge monitor
module tb_dram_arb;
    logic        fclk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cpu_req = 1'b0, cpu_rnw = 1'b1, cpu_wrbsel = 1'b0;
    logic [20:0] cpu_addr = '0, video_addr = '0;
    logic [7:0]  cpu_wrdata = '0;
    logic        video_req = 1'b0;
    logic [15:0] dram_rddata = '0;
    logic [15:0] cpu_rddata, video_rddata, dram_wrdata;
    logic        cpu_strobe, video_strobe, pre_cend, cend, dram_req, dram_rnw;
    logic [20:0] dram_addr;
    logic [1:0]  dram_bsel;

    typedef struct packed {
        logic        req;
        logic        rnw;
        logic [1:0]  bsel;
        logic [20:0] addr;
        logic [15:0] wd;
    } cmd_t;

    cmd_t        cmd_q[$];
    logic [15:0] cpu_q[$];
    logic [15:0] vid_q[$];
    int          checks = 0;
    int          failures = 0;
    logic [1:0]  prev_own = 2'd0;
    logic        prev_rnw = 1'b1;

    dram_arb dut (
        .fclk         (fclk),
        .rst_n        (rst_n),
        .cpu_req      (cpu_req),
        .cpu_rnw      (cpu_rnw),
        .cpu_addr     (cpu_addr),
        .cpu_wrdata   (cpu_wrdata),
        .cpu_wrbsel   (cpu_wrbsel),
        .cpu_rddata   (cpu_rddata),
        .cpu_strobe   (cpu_strobe),
        .video_req    (video_req),
        .video_addr   (video_addr),
        .video_rddata (video_rddata),
        .video_strobe (video_strobe),
        .pre_cend     (pre_cend),
        .cend         (cend),
        .dram_req     (dram_req),
        .dram_rnw     (dram_rnw),
        .dram_addr    (dram_addr),
        .dram_wrdata  (dram_wrdata),
        .dram_bsel    (dram_bsel),
        .dram_rddata  (dram_rddata)
    );

    always #5 fclk = ~fclk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    // Monitor: command at cyc 0, strobes, and slot phase spacing
    logic        last_cend = 1'b0, last_pre = 1'b0, last_cstb = 1'b0, last_vstb = 1'b0, have_cend = 1'b0;
    int          gap = 0;
    cmd_t        exp_c, got_c;
    logic [15:0] exp_d;
    always @(negedge fclk) begin
        if (last_cend && cmd_q.size() > 0) begin
            exp_c = cmd_q.pop_front();
            got_c.req  = dram_req;
            got_c.rnw  = dram_rnw;
            got_c.bsel = dram_bsel;
            got_c.addr = exp_c.req ? dram_addr : 21'h0;
            got_c.wd   = (exp_c.req && !exp_c.rnw) ? dram_wrdata : 16'h0;
            checks++;
            if (got_c !== exp_c) begin
                failures++;
                $display("FAIL dram_cmd got req=%b rnw=%b bsel=%b addr=%h wd=%h expected req=%b rnw=%b bsel=%b addr=%h wd=%h",
                         got_c.req, got_c.rnw, got_c.bsel, got_c.addr, got_c.wd,
                         exp_c.req, exp_c.rnw, exp_c.bsel, exp_c.addr, exp_c.wd);
            end
        end
        if (cpu_strobe) begin
            checks++;
            if (cpu_q.size() == 0) begin
                failures++;
                $display("FAIL cpu_strobe unexpected data=%h", cpu_rddata);
            end else begin
                exp_d = cpu_q.pop_front();
                if (cpu_rddata !== exp_d || last_cstb || !last_cend) begin
                    failures++;
                    $display("FAIL cpu_read got=%h expected=%h after_cend=%b repeat=%b", cpu_rddata, exp_d, last_cend, last_cstb);
                end
            end
        end
        if (video_strobe) begin
            checks++;
            if (vid_q.size() == 0) begin
                failures++;
                $display("FAIL video_strobe unexpected data=%h", video_rddata);
            end else begin
                exp_d = vid_q.pop_front();
                if (video_rddata !== exp_d || last_vstb || !last_cend) begin
                    failures++;
                    $display("FAIL video_read got=%h expected=%h after_cend=%b repeat=%b", video_rddata, exp_d, last_cend, last_vstb);
                end
            end
        end
        gap++;
        if (!rst_n) have_cend = 1'b0;
        else if (cend) begin
            if (have_cend) begin
                checks++;
                if (gap != 4 || !last_pre || pre_cend) begin
                    failures++;
                    $display("FAIL cend_period got=%0d pre_before=%b expected=4 pre_before=1", gap, last_pre);
                end
            end
            have_cend = 1'b1;
            gap = 0;
        end
        last_cend = cend;
        last_pre  = pre_cend;
        last_cstb = cpu_strobe;
        last_vstb = video_strobe;
    end

    // Called at a negedge; leaves rst_n high at the first cend after release
    task automatic do_reset();
        int n;
        logic [76:0] got;
        rst_n = 1'b0;
        prev_own = 2'd0;
        @(negedge fclk);
        @(negedge fclk);
        got = {dram_req, dram_rnw, dram_bsel, dram_addr, dram_wrdata, cpu_rddata, video_rddata,
               cpu_strobe, video_strobe, pre_cend, cend};
        checks++;
        if (got !== {1'b0, 1'b1, 2'b00, 21'h0, 16'h0, 16'h0, 16'h0, 4'b0000}) begin
            failures++;
            $display("FAIL reset_state got=%h expected=%h", got, {1'b0, 1'b1, 2'b00, 21'h0, 16'h0, 16'h0, 16'h0, 4'b0000});
        end
        rst_n = 1'b1;
        n = 0;
        while (!cend && n < 10) begin
            @(negedge fclk);
            n++;
        end
        checks++;
        if (n != 3) begin
            failures++;
            $display("FAIL first_cend got=%0d negedges expected=3", n);
        end
    endtask

    // One slot: drive requests at cend, supply read data for the slot now ending, queue expectations
    task automatic slot(input logic creq, input logic crnw, input logic [20:0] caddr, input logic [7:0] cwd,
                        input logic cbs, input logic vreq, input logic [20:0] vaddr, input logic [15:0] rd,
                        input logic [1:0] eown, input logic ernw, input logic [20:0] eaddr,
                        input logic [15:0] ewd, input logic [1:0] ebsel);
        int   n;
        cmd_t e;
        n = 0;
        while (!cend && n < 8) begin
            @(negedge fclk);
            n++;
        end
        if (!cend) begin
            checks++;
            failures++;
            $display("FAIL cend_timeout got=no_cend expected=cend within 8 cycles");
        end
        cpu_req     = creq;
        cpu_rnw     = crnw;
        cpu_addr    = caddr;
        cpu_wrdata  = cwd;
        cpu_wrbsel  = cbs;
        video_req   = vreq;
        video_addr  = vaddr;
        dram_rddata = rd;
        if (prev_own == 2'd1 && prev_rnw) cpu_q.push_back(rd);
        if (prev_own == 2'd2) vid_q.push_back(rd);
        e.req  = eown != 2'd0;
        e.rnw  = ernw;
        e.bsel = ebsel;
        e.addr = (eown != 2'd0) ? eaddr : 21'h0;
        e.wd   = (eown != 2'd0 && !ernw) ? ewd : 16'h0;
        cmd_q.push_back(e);
        prev_own = eown;
        prev_rnw = ernw;
        @(negedge fclk);
        cpu_req = 1'b0;
    endtask

    task automatic idle(input logic [15:0] rd);
        slot(0, 1, 21'h0, 8'h0, 0, 0, 21'h0, rd, 2'd0, 1, 21'h0, 16'h0, 2'b00);
    endtask

    initial begin
        @(negedge fclk);
        do_reset();
        // collision on the first cend after reset: video first, then latched CPU read
        slot(1, 1, 21'h01234, 8'h00, 0, 1, 21'h1AAAA, 16'h0000, 2'd2, 1, 21'h1AAAA, 16'h0, 2'b11);
        slot(0, 1, 21'h00000, 8'h00, 0, 1, 21'h1AAAB, 16'hBEEF, 2'd1, 1, 21'h01234, 16'h0, 2'b11);
        slot(0, 1, 21'h00000, 8'h00, 0, 1, 21'h1AAAC, 16'hA55A, 2'd2, 1, 21'h1AAAC, 16'h0, 2'b11);
        slot(1, 0, 21'h00F00, 8'h3C, 0, 1, 21'h1AAAD, 16'h1111, 2'd1, 0, 21'h00F00, 16'h3C3C, 2'b10);
        idle(16'h2222);
        slot(1, 1, 21'h01234, 8'h00, 0, 0, 21'h00000, 16'h0000, 2'd1, 1, 21'h01234, 16'h0, 2'b11);
        idle(16'hA55A);
        slot(1, 0, 21'h00ABC, 8'h5A, 1, 0, 21'h00000, 16'h0000, 2'd1, 0, 21'h00ABC, 16'h5A5A, 2'b01);
        idle(16'h7777);
        idle(16'h0000);
        idle(16'h0000);
        // continuous video, CPU every third slot
        slot(1, 1, 21'h00100, 8'h00, 0, 1, 21'h10000, 16'h0000, 2'd2, 1, 21'h10000, 16'h0, 2'b11);
        slot(0, 1, 21'h00000, 8'h00, 0, 1, 21'h10001, 16'h0001, 2'd1, 1, 21'h00100, 16'h0, 2'b11);
        slot(0, 1, 21'h00000, 8'h00, 0, 1, 21'h10002, 16'hC001, 2'd2, 1, 21'h10002, 16'h0, 2'b11);
        slot(1, 1, 21'h00200, 8'h00, 0, 1, 21'h10003, 16'h0002, 2'd1, 1, 21'h00200, 16'h0, 2'b11);
        slot(0, 1, 21'h00000, 8'h00, 0, 1, 21'h10004, 16'hC002, 2'd2, 1, 21'h10004, 16'h0, 2'b11);
        slot(0, 1, 21'h00000, 8'h00, 0, 1, 21'h10005, 16'h0003, 2'd2, 1, 21'h10005, 16'h0, 2'b11);
        slot(1, 1, 21'h00300, 8'h00, 0, 1, 21'h10006, 16'h0004, 2'd1, 1, 21'h00300, 16'h0, 2'b11);
        slot(0, 1, 21'h00000, 8'h00, 0, 1, 21'h10007, 16'hC003, 2'd2, 1, 21'h10007, 16'h0, 2'b11);
        idle(16'h0005);
        // CPU slot followed by a collision: video wins, CPU follows
        slot(1, 1, 21'h00400, 8'h00, 0, 0, 21'h00000, 16'h0000, 2'd1, 1, 21'h00400, 16'h0, 2'b11);
        slot(1, 1, 21'h00500, 8'h00, 0, 1, 21'h10008, 16'hC004, 2'd2, 1, 21'h10008, 16'h0, 2'b11);
        slot(0, 1, 21'h00000, 8'h00, 0, 1, 21'h10009, 16'h0006, 2'd1, 1, 21'h00500, 16'h0, 2'b11);
        idle(16'hC005);
        idle(16'h0000);
        // reset at cyc 1 of a CPU read slot aborts it
        slot(1, 1, 21'h01234, 8'h00, 0, 0, 21'h00000, 16'h0000, 2'd1, 1, 21'h01234, 16'h0, 2'b11);
        @(negedge fclk);
        do_reset();
        idle(16'hFFFF);
        idle(16'hFFFF);
        // reset with a CPU request pending discards it
        slot(1, 1, 21'h00777, 8'h00, 0, 1, 21'h1BBBB, 16'h0000, 2'd2, 1, 21'h1BBBB, 16'h0, 2'b11);
        @(negedge fclk);
        do_reset();
        idle(16'hFFFF);
        idle(16'hFFFF);
        idle(16'hFFFF);
        repeat (6) @(negedge fclk);
        checks++;
        if (cpu_q.size() != 0 || vid_q.size() != 0 || cmd_q.size() != 0) begin
            failures++;
            $display("FAIL queues_drained got cpu=%0d video=%0d cmd=%0d expected 0 0 0", cpu_q.size(), vid_q.size(), cmd_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
